// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter one byte per frame, using a
// launch / wait-for-busy / wait-for-done handshake with a busy-rise timeout.
module uart_tx_feeder #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int BUSY_TMO = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          tx_en,
  output logic [7:0]    tx_dat,
  input  logic          tx_busy,
  output logic          tx_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [2:0]    TMO_LAST = 3'(BUSY_TMO - 1);

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      tx_dat_q, tx_dat_d;
  logic            tx_en_q, overflow_q, tx_err_q;
  logic            push, drop, pop, timeout;

  // full/empty come straight from the level register, so acceptance never
  // depends on a same-cycle pop.
  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign tx_en    = tx_en_q;
  assign tx_dat   = tx_dat_q;
  assign tx_err   = tx_err_q;

  assign push = wr_en & ~full;
  assign drop = wr_en & full;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!empty && !tx_busy) state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)                state_d = WAIT_DONE;
        else if (cnt_q == TMO_LAST) state_d = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    pop     = (state_q == IDLE) && !empty && !tx_busy;
    timeout = (state_q == WAIT_BUSY) && !tx_busy && (cnt_q == TMO_LAST);
    cnt_d   = (state_q == WAIT_BUSY) ? cnt_q + 3'd1 : 3'd0;
  end

  // FIFO bookkeeping and transmitter holding register
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    tx_dat_d = tx_dat_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      tx_dat_d = mem_q[rd_ptr_q];
    end
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (!push && pop) level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tx_dat_q   <= 8'h00;
      tx_en_q    <= 1'b0;
      overflow_q <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tx_dat_q   <= tx_dat_d;
      tx_en_q    <= pop;
      overflow_q <= drop;
      tx_err_q   <= timeout;
    end
  end

  // NOTE: storage has no reset; stale bytes are unreachable once the pointers and level clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small transmitter busy model.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_dat = 8'h00;
  logic          full, empty, overflow, tx_en, tx_err;
  logic [AW:0]   level;
  logic [7:0]    tx_dat;
  logic          tx_busy = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  // Busy-model controls, written only by the stimulus process.
  bit model_en  = 1'b1;
  bit hold_busy = 1'b0;
  int busy_len  = 1;

  // Monitor/model state, written only by the negedge process.
  logic       m_busy    = 1'b0;
  int         pend      = 0;
  int         busy_left = 0;
  int         ovf_cnt   = 0;
  int         err_cnt   = 0;
  logic [7:0] tx_log [$];

  uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW), .BUSY_TMO(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_dat   (wr_dat),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_en    (tx_en),
    .tx_dat   (tx_dat),
    .tx_busy  (tx_busy),
    .tx_err   (tx_err)
  );

  always #10 clk = ~clk;

  // Transmitter: busy rises two cycles after tx_en and stays high busy_len cycles.
  always @(negedge clk) begin
    if (tx_en) begin
      tx_log.push_back(tx_dat);
      if (model_en) pend = 2;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        m_busy    = 1'b1;
        busy_left = busy_len;
      end
    end else if (m_busy) begin
      if (busy_left <= 1) m_busy = 1'b0;
      else busy_left--;
    end
    if (overflow) ovf_cnt++;
    if (tx_err)   err_cnt++;
    tx_busy = m_busy | hold_busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] seq_byte(input int n);
    return 8'(n * 37 + 11);
  endfunction

  task automatic test_reset();
    logic [17:0] exp_v;
    rst = 1'b1;
    tick();
    tick();
    exp_v = {1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    n_total++;
    if ({empty, full, level, tx_en, tx_dat, overflow, tx_err} !== exp_v)
      $display("FAIL reset_vec: got %h want %h",
               {empty, full, level, tx_en, tx_dat, overflow, tx_err}, exp_v);
    else n_pass++;
    rst = 1'b0;
    tick();
    tick();
    n_total++;
    if ({empty, full, level, tx_en, tx_dat, overflow, tx_err} !== exp_v)
      $display("FAIL reset_idle: got %h want %h",
               {empty, full, level, tx_en, tx_dat, overflow, tx_err}, exp_v);
    else n_pass++;
  endtask

  task automatic test_single();
    int base;
    busy_len = 40;
    model_en = 1'b1;
    base = tx_log.size();
    wr_en = 1'b1; wr_dat = 8'hA5;
    tick();
    wr_en = 1'b0;
    n_total++;
    if ({empty, tx_en, level} !== {1'b0, 1'b0, 5'd1})
      $display("FAIL single_queued: got %b want %b", {empty, tx_en, level}, {1'b0, 1'b0, 5'd1});
    else n_pass++;
    tick();
    n_total++;
    if ({tx_en, tx_dat} !== {1'b1, 8'hA5})
      $display("FAIL single_launch: got %h want %h", {tx_en, tx_dat}, {1'b1, 8'hA5});
    else n_pass++;
    tick();
    n_total++;
    if ({tx_en, empty} !== 2'b01)
      $display("FAIL single_pulse: got %b want 01", {tx_en, empty});
    else n_pass++;
    repeat (45) tick();
    n_total++;
    if (tx_log.size() - base != 1)
      $display("FAIL single_count: got %0d want 1", tx_log.size() - base);
    else n_pass++;
    n_total++;
    if ({tx_dat, empty} !== {8'hA5, 1'b1})
      $display("FAIL single_hold: got %h want %h", {tx_dat, empty}, {8'hA5, 1'b1});
    else n_pass++;
    for (int t = 0; t < 60 && tx_busy; t++) tick();
    repeat (3) tick();
  endtask

  task automatic test_burst_overflow();
    int base, ob, last, bad, seen, ff_seen;
    bit found;
    busy_len  = 1;
    hold_busy = 1'b1;
    tick();
    base = tx_log.size();
    ob   = ovf_cnt;
    for (int i = 0; i < 16; i++) begin
      wr_en  = 1'b1;
      wr_dat = 8'(i + 1);
      tick();
    end
    n_total++;
    if ({full, level} !== {1'b1, 5'd16})
      $display("FAIL burst_full: got %b want %b", {full, level}, {1'b1, 5'd16});
    else n_pass++;
    wr_dat = 8'hFF;
    tick();
    wr_en = 1'b0;
    n_total++;
    if ({overflow, full, level} !== {1'b1, 1'b1, 5'd16})
      $display("FAIL ovf_pulse: got %b want %b", {overflow, full, level}, {1'b1, 1'b1, 5'd16});
    else n_pass++;
    tick();
    n_total++;
    if (overflow !== 1'b0 || ovf_cnt - ob != 1)
      $display("FAIL ovf_once: got ovf=%b pulses=%0d want 0/1", overflow, ovf_cnt - ob);
    else n_pass++;

    hold_busy = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (tx_en) begin found = 1'b1; break; end
    end
    n_total++;
    if (!found || {full, level} !== {1'b0, 5'd15})
      $display("FAIL burst_first_pop: got found=%b full/level=%b want 1/%b",
               found, {full, level}, {1'b0, 5'd15});
    else n_pass++;

    last = 0; bad = 0; seen = 1;
    for (int t = 1; t <= 200 && seen < 16; t++) begin
      tick();
      if (tx_en) begin
        if (t - last != 5) bad++;
        last = t;
        seen++;
      end
    end
    n_total++;
    if (seen != 16 || bad != 0)
      $display("FAIL burst_spacing: got launches=%0d bad_gaps=%0d want 16/0", seen, bad);
    else n_pass++;
    repeat (10) tick();
    n_total++;
    if (empty !== 1'b1)
      $display("FAIL burst_empty: got %b want 1", empty);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (tx_log.size() <= base + i || tx_log[base + i] !== 8'(i + 1))
        $display("FAIL burst_order[%0d]: got %h want %h", i,
                 (tx_log.size() > base + i) ? tx_log[base + i] : 8'hxx, 8'(i + 1));
      else n_pass++;
    end
    ff_seen = 0;
    for (int i = base; i < tx_log.size(); i++) if (tx_log[i] == 8'hFF) ff_seen++;
    n_total++;
    if (ff_seen != 0)
      $display("FAIL ovf_dropped: got %0d launches of FF want 0", ff_seen);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int eb, k;
    busy_len = 3;
    model_en = 1'b0;
    eb = err_cnt;
    wr_en = 1'b1; wr_dat = 8'h3C;
    tick();
    wr_dat = 8'h5A;
    tick();
    wr_en = 1'b0;
    n_total++;
    if ({tx_en, tx_dat} !== {1'b1, 8'h3C})
      $display("FAIL tmo_launch: got %h want %h", {tx_en, tx_dat}, {1'b1, 8'h3C});
    else n_pass++;
    tick();
    model_en = 1'b1;
    k = 1;
    while (!tx_err && k < 20) begin
      tick();
      k++;
    end
    n_total++;
    if (tx_err !== 1'b1 || k != 7)
      $display("FAIL tmo_err_time: got err=%b at cycle %0d want 1 at 7", tx_err, k);
    else n_pass++;
    tick();
    n_total++;
    if ({tx_en, tx_dat, tx_err} !== {1'b1, 8'h5A, 1'b0})
      $display("FAIL tmo_next_launch: got %h want %h",
               {tx_en, tx_dat, tx_err}, {1'b1, 8'h5A, 1'b0});
    else n_pass++;
    repeat (20) tick();
    n_total++;
    if (err_cnt - eb != 1 || empty !== 1'b1)
      $display("FAIL tmo_err_count: got errs=%0d empty=%b want 1/1", err_cnt - eb, empty);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int base;
    bit found;
    busy_len  = 1;
    model_en  = 1'b1;
    hold_busy = 1'b1;
    tick();
    base = tx_log.size();
    for (int n = 0; n < 4; n++) begin
      wr_en  = 1'b1;
      wr_dat = seq_byte(n);
      tick();
    end
    wr_en = 1'b0;
    hold_busy = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (tx_en) begin found = 1'b1; break; end
    end
    n_total++;
    if (!found || level !== 5'd3)
      $display("FAIL b2b_start: got found=%b level=%0d want 1/3", found, level);
    else n_pass++;
    for (int n = 4; n < 44; n++) begin
      repeat (4) tick();
      wr_en  = 1'b1;
      wr_dat = seq_byte(n);
      tick();
      wr_en = 1'b0;
      n_total++;
      if ({tx_en, level} !== {1'b1, 5'd3})
        $display("FAIL b2b_step[%0d]: got en/level=%b want %b", n, {tx_en, level}, {1'b1, 5'd3});
      else n_pass++;
    end
    repeat (25) tick();
    n_total++;
    if (tx_log.size() - base != 44 || empty !== 1'b1)
      $display("FAIL b2b_count: got %0d empty=%b want 44/1", tx_log.size() - base, empty);
    else n_pass++;
    for (int n = 0; n < 44; n++) begin
      n_total++;
      if (tx_log.size() <= base + n || tx_log[base + n] !== seq_byte(n))
        $display("FAIL b2b_order[%0d]: got %h want %h", n,
                 (tx_log.size() > base + n) ? tx_log[base + n] : 8'hxx, seq_byte(n));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int launches;
    bit found;
    logic [17:0] exp_v;
    busy_len  = 30;
    model_en  = 1'b1;
    hold_busy = 1'b1;
    tick();
    for (int n = 0; n < 6; n++) begin
      wr_en  = 1'b1;
      wr_dat = 8'(8'hC0 + n);
      tick();
    end
    wr_en = 1'b0;
    hold_busy = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (tx_en) begin found = 1'b1; break; end
    end
    repeat (4) tick();
    n_total++;
    if (!found || {level, tx_busy} !== {5'd5, 1'b1})
      $display("FAIL rstmid_pre: got found=%b level/busy=%b want 1/%b",
               found, {level, tx_busy}, {5'd5, 1'b1});
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_v = {1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    n_total++;
    if ({empty, full, level, tx_en, tx_dat, overflow, tx_err} !== exp_v)
      $display("FAIL rstmid_vec: got %h want %h",
               {empty, full, level, tx_en, tx_dat, overflow, tx_err}, exp_v);
    else n_pass++;
    launches = tx_log.size();
    for (int t = 0; t < 60 && tx_busy; t++) tick();
    repeat (10) tick();
    n_total++;
    if (tx_log.size() != launches || empty !== 1'b1)
      $display("FAIL rstmid_flush: got %0d new launches empty=%b want 0/1",
               tx_log.size() - launches, empty);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
